// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for IF/ID/EX: load-use stalls, branch flushes,
// HLT parking and a saturating stall statistics counter.
module pipe_hazard_ctrl #(
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_in,
  input  logic        resume_in,
  input  logic        id_valid_in,
  input  logic        id_uses_src_in,
  input  logic        id_uses_tgt_in,
  input  logic [3:0]  id_src_gp_in,
  input  logic [3:0]  id_tgt_gp_in,
  input  logic        ex_valid_in,
  input  logic        ex_is_load_in,
  input  logic        ex_writes_gp_in,
  input  logic [3:0]  ex_tgt_gp_in,
  input  logic        halt_in,
  input  logic        branch_taken_in,
  input  logic [11:0] branch_target_in,
  output logic        if_en_out,
  output logic        id_en_out,
  output logic        ex_en_out,
  output logic        bubble_out,
  output logic        flush_out,
  output logic        pc_load_out,
  output logic [11:0] pc_target_out,
  output logic        halted_out,
  output logic [11:0] stall_count_out
);

  localparam int CMAX = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] LD_INIT = CW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [CW-1:0] FL_INIT = CW'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);

  typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          hit, hz;

  assign hit = (id_uses_src_in && id_src_gp_in == ex_tgt_gp_in)
             | (id_uses_tgt_in && id_tgt_gp_in == ex_tgt_gp_in);
  assign hz  = id_valid_in & ex_valid_in & ex_is_load_in
             & ex_writes_gp_in & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    if_en_out     = 1'b0;
    id_en_out     = 1'b0;
    ex_en_out     = 1'b0;
    bubble_out    = 1'b0;
    flush_out     = 1'b0;
    pc_load_out   = 1'b0;
    pc_target_out = 12'h000;
    halted_out    = 1'b0;
    if (!rst) begin
      halted_out = (state == HALT);
      if (run_in) begin
        unique case (state)
          RUN, STALL: begin
            if (halt_in) begin
              state_nx = HALT;
            end else if (branch_taken_in) begin
              if_en_out     = 1'b1;
              id_en_out     = 1'b1;
              ex_en_out     = 1'b1;
              flush_out     = 1'b1;
              pc_load_out   = 1'b1;
              pc_target_out = branch_target_in;
              if (FLUSH_DEPTH > 1) begin
                state_nx = FLUSH;
                cnt_nx   = FL_INIT;
              end else begin
                state_nx = RUN;
              end
            end else if (state == STALL || hz) begin
              ex_en_out  = 1'b1;
              bubble_out = 1'b1;
              if (state == STALL) begin
                if (cnt == '0) state_nx = RUN;
                else           cnt_nx   = cnt - 1'b1;
              end else if (LOAD_LAT > 1) begin
                state_nx = STALL;
                cnt_nx   = LD_INIT;
              end
            end else begin
              if_en_out = 1'b1;
              id_en_out = 1'b1;
              ex_en_out = 1'b1;
            end
          end
          FLUSH: begin
            if_en_out = 1'b1;
            id_en_out = 1'b1;
            ex_en_out = 1'b1;
            flush_out = 1'b1;
            if (cnt == '0) state_nx = RUN;
            else           cnt_nx   = cnt - 1'b1;
          end
          HALT: begin
            if (resume_in) state_nx = RUN;
          end
          default: state_nx = RUN;
        endcase
      end
    end
  end

  // Saturating count of bubble cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count_out <= '0;
    else if (bubble_out && stall_count_out != 12'hFFF)
      stall_count_out <= stall_count_out + 12'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stall, flush, halt, freeze,
// saturation and reset-abort sequences.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_in, resume_in;
  logic        id_valid_in, id_uses_src_in, id_uses_tgt_in;
  logic [3:0]  id_src_gp_in, id_tgt_gp_in;
  logic        ex_valid_in, ex_is_load_in, ex_writes_gp_in;
  logic [3:0]  ex_tgt_gp_in;
  logic        halt_in, branch_taken_in;
  logic [11:0] branch_target_in;
  logic        if_en_out, id_en_out, ex_en_out, bubble_out;
  logic        flush_out, pc_load_out, halted_out;
  logic [11:0] pc_target_out, stall_count_out;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.LOAD_LAT(2), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .run_in(run_in), .resume_in(resume_in),
    .id_valid_in(id_valid_in), .id_uses_src_in(id_uses_src_in),
    .id_uses_tgt_in(id_uses_tgt_in), .id_src_gp_in(id_src_gp_in),
    .id_tgt_gp_in(id_tgt_gp_in), .ex_valid_in(ex_valid_in),
    .ex_is_load_in(ex_is_load_in), .ex_writes_gp_in(ex_writes_gp_in),
    .ex_tgt_gp_in(ex_tgt_gp_in), .halt_in(halt_in),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .if_en_out(if_en_out), .id_en_out(id_en_out), .ex_en_out(ex_en_out),
    .bubble_out(bubble_out), .flush_out(flush_out),
    .pc_load_out(pc_load_out), .pc_target_out(pc_target_out),
    .halted_out(halted_out), .stall_count_out(stall_count_out)
  );

  always #5 clk = ~clk;

  // {if_en, id_en, ex_en, bubble, flush, pc_load, halted}
  function automatic logic [6:0] outs();
    return {if_en_out, id_en_out, ex_en_out, bubble_out,
            flush_out, pc_load_out, halted_out};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hz(input logic on);
    ex_valid_in     = on;
    ex_is_load_in   = on;
    ex_writes_gp_in = on;
    ex_tgt_gp_in    = 4'd3;
    id_valid_in     = on;
    id_uses_src_in  = on;
    id_src_gp_in    = 4'd3;
  endtask

  initial begin
    run_in = 1'b1; resume_in = 1'b0;
    id_valid_in = 1'b1; id_uses_src_in = 1'b1; id_uses_tgt_in = 1'b0;
    id_src_gp_in = 4'd3; id_tgt_gp_in = 4'd7;
    ex_valid_in = 1'b1; ex_is_load_in = 1'b1; ex_writes_gp_in = 1'b1;
    ex_tgt_gp_in = 4'd3;
    halt_in = 1'b0; branch_taken_in = 1'b1; branch_target_in = 12'h155;

    // Reset with active inputs: all outputs forced low
    step();
    #1;
    chk("rst_outs", 12'(outs()), 12'h000);
    chk("rst_tgt", pc_target_out, 12'h000);
    chk("rst_cnt", stall_count_out, 12'h000);

    set_hz(1'b0);
    id_uses_tgt_in = 1'b1;
    branch_taken_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("run_idle", 12'(outs()), 12'h070);

    // Load-use on src r3
    step();
    set_hz(1'b1);
    #1;
    chk("hz_c0", 12'(outs()), 12'h018);
    step();
    set_hz(1'b0);
    #1;
    chk("hz_c1", 12'(outs()), 12'h018);
    chk("hz_cnt1", stall_count_out, 12'd1);
    step();
    chk("hz_done", 12'(outs()), 12'h070);
    chk("hz_cnt2", stall_count_out, 12'd2);

    // Hazard through tgt port only
    id_valid_in = 1'b1; id_uses_src_in = 1'b0; id_uses_tgt_in = 1'b1;
    id_src_gp_in = 4'd1; id_tgt_gp_in = 4'd9;
    ex_valid_in = 1'b1; ex_is_load_in = 1'b1; ex_writes_gp_in = 1'b1;
    ex_tgt_gp_in = 4'd9;
    #1;
    chk("hz_tgt", 12'(outs()), 12'h018);
    ex_tgt_gp_in = 4'd8;
    #1;
    chk("no_hit", 12'(outs()), 12'h070);
    set_hz(1'b0);

    // Taken branch
    branch_taken_in = 1'b1; branch_target_in = 12'h1A4;
    #1;
    chk("br_outs", 12'(outs()), 12'h076);
    chk("br_tgt", pc_target_out, 12'h1A4);
    step();
    branch_taken_in = 1'b0;
    halt_in = 1'b1;
    #1;
    chk("fl_outs", 12'(outs()), 12'h074);
    chk("fl_tgt", pc_target_out, 12'h000);
    step();
    halt_in = 1'b0;
    #1;
    chk("fl_done", 12'(outs()), 12'h070);

    // Hazard and branch together: branch wins
    set_hz(1'b1);
    branch_taken_in = 1'b1; branch_target_in = 12'h2B0;
    #1;
    chk("hzbr_outs", 12'(outs()), 12'h076);
    chk("hzbr_tgt", pc_target_out, 12'h2B0);
    step();
    set_hz(1'b0);
    branch_taken_in = 1'b0;
    #1;
    chk("hzbr_fl", 12'(outs()), 12'h074);
    step();
    chk("hzbr_cnt", stall_count_out, 12'd2);

    // Halt and resume
    halt_in = 1'b1;
    #1;
    chk("hlt_c0", 12'(outs()), 12'h000);
    step();
    halt_in = 1'b0;
    #1;
    chk("hlt_c1", 12'(outs()), 12'h001);
    for (int i = 2; i <= 4; i++) begin
      step();
      halt_in = (i == 3);
      #1;
      chk("hlt_hold", 12'(outs()), 12'h001);
    end
    step();
    halt_in = 1'b0;
    resume_in = 1'b1;
    #1;
    chk("hlt_res", 12'(outs()), 12'h001);
    step();
    resume_in = 1'b0;
    #1;
    chk("hlt_run", 12'(outs()), 12'h070);

    // Freeze during a stall
    rst = 1'b1;
    #1;
    chk("rst2_cnt", stall_count_out, 12'd0);
    rst = 1'b0;
    set_hz(1'b1);
    #1;
    chk("frz_hz", 12'(outs()), 12'h018);
    step();
    set_hz(1'b0);
    run_in = 1'b0;
    #1;
    chk("frz_c0", 12'(outs()), 12'h000);
    step();
    step();
    chk("frz_c2", 12'(outs()), 12'h000);
    chk("frz_cnt", stall_count_out, 12'd1);
    step();
    run_in = 1'b1;
    #1;
    chk("frz_rest", 12'(outs()), 12'h018);
    step();
    chk("frz_done", 12'(outs()), 12'h070);
    chk("frz_cnt2", stall_count_out, 12'd2);

    // Saturation
    set_hz(1'b1);
    repeat (4200) step();
    chk("sat_outs", 12'(outs()), 12'h018);
    chk("sat_cnt", stall_count_out, 12'hFFF);
    step();
    chk("sat_hold", stall_count_out, 12'hFFF);
    set_hz(1'b0);
    step();
    step();
    chk("sat_run", 12'(outs()), 12'h070);

    // Reset in the middle of a flush
    branch_taken_in = 1'b1; branch_target_in = 12'h3C0;
    step();
    branch_taken_in = 1'b0;
    #1;
    chk("rfl_fl", 12'(outs()), 12'h074);
    rst = 1'b1;
    #1;
    chk("rfl_outs", 12'(outs()), 12'h000);
    chk("rfl_cnt", stall_count_out, 12'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rfl_run", 12'(outs()), 12'h070);
    chk("rfl_tgt", pc_target_out, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
